// File: rtl/bus_timeout_mon.sv
// bus_timeout_mon: multi-channel bus cycle timeout monitor.
// Each of NCH master ports runs its own IDLE/COUNT/ERR machine against a
// shared runtime limit (to_i, or pTO when to_i is zero). Addresses inside
// [pEXC_LO, pEXC_HI] are exempt: hitting the limit there reloads the counter.
// Optional logging of the first timeout is enabled by defining the macro
// BUS_TIMEOUT_LOG_EN; without it sts_o/cap_adr_o/cap_ch_o are constant 0.
module bus_timeout_mon #(
  parameter int unsigned     NCH     = 4,
  parameter int unsigned     AW      = 32,
  parameter int unsigned     TW      = 28,
  parameter int unsigned     pTO     = 250,
  parameter logic [AW-1:0]   pEXC_LO = 32'hFFDCFFE0,
  parameter logic [AW-1:0]   pEXC_HI = 32'hFFDCFFEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NCH-1:0]    cyc_i,
  input  logic [NCH-1:0]    stb_i,
  input  logic [NCH-1:0]    ack_i,
  input  logic [NCH*AW-1:0] adr_i,
  input  logic [TW-1:0]     to_i,
  input  logic [NCH-1:0]    en_i,
  output logic [NCH-1:0]    err_o,
  output logic              irq_o,
  output logic [NCH-1:0]    sts_o,
  output logic [AW-1:0]     cap_adr_o,
  output logic [3:0]        cap_ch_o,
  input  logic              clr_i
);

  localparam logic [TW-1:0] TO_DEF   = TW'(pTO);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] CNT_TWO  = TW'(2'd2);
  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_COUNT = 2'd1;
  localparam logic [1:0]    ST_ERR   = 2'd2;

  logic [TW-1:0]  lim_s;
  logic [NCH-1:0] err_r;
  logic [NCH-1:0] err_nxt_s;
  logic [NCH-1:0] ent_s;
  logic           irq_r;

  // Effective limit: zero on to_i selects the built-in default.
  always_comb begin
    if (to_i == {TW{1'b0}}) begin
      lim_s = TO_DEF;
    end else begin
      lim_s = to_i;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_nxt_s;
    logic [AW-1:0] adr_s;
    logic          active_s;
    logic          exempt_s;

    assign adr_s    = adr_i[g*AW +: AW];
    // A cycle keeps counting only while it is open, monitored and unanswered.
    assign active_s = cyc_i[g] & en_i[g] & ~ack_i[g];
    assign exempt_s = stb_i[g] & (adr_s >= pEXC_LO) & (adr_s <= pEXC_HI);

    // Channel FSM next-state and counter update; counter saturates at lim.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
        ST_IDLE: begin
          if (active_s) begin
            state_nxt_s = ST_COUNT;
            cnt_nxt_s   = CNT_TWO;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ONE;
          end
        end
        ST_COUNT: begin
          if (!active_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ONE;
          end else if (cnt_r < lim_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else if (exempt_s) begin
            cnt_nxt_s = CNT_ONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end
        ST_ERR: begin
          if (!active_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ONE;
        end
      endcase
    end

    // Error is shown the cycle after ERR is entered and dropped as the exit is taken.
    assign err_nxt_s[g] = (state_r == ST_ERR) & active_s;
    assign ent_s[g]     = err_nxt_s[g] & ~err_r[g];

    // Channel state and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_r <= ST_IDLE;
        cnt_r   <= CNT_ONE;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
      end
    end
  end

  // Held per-channel errors and the single-cycle interrupt on any new error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= {NCH{1'b0}};
      irq_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
      irq_r <= |ent_s;
    end
  end

  assign err_o = err_r;
  assign irq_o = irq_r;

`ifdef BUS_TIMEOUT_LOG_EN
  logic [NCH-1:0] sts_r;
  logic [AW-1:0]  cap_adr_r;
  logic [3:0]     cap_ch_r;
  logic [AW-1:0]  first_adr_s;
  logic [3:0]     first_ch_s;

  // Pick the lowest-index channel among those entering error this cycle.
  always_comb begin
    first_adr_s = {AW{1'b0}};
    first_ch_s  = 4'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ent_s[i]) begin
        first_adr_s = adr_i[i*AW +: AW];
        first_ch_s  = 4'(i);
      end else begin
        first_adr_s = first_adr_s;
        first_ch_s  = first_ch_s;
      end
    end
  end

  // Sticky status and first-error capture; a new entry beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sts_r     <= {NCH{1'b0}};
      cap_adr_r <= {AW{1'b0}};
      cap_ch_r  <= 4'd0;
    end else if (ent_s != {NCH{1'b0}}) begin
      sts_r <= (clr_i ? {NCH{1'b0}} : sts_r) | ent_s;
      if (clr_i || (sts_r == {NCH{1'b0}})) begin
        cap_adr_r <= first_adr_s;
        cap_ch_r  <= first_ch_s;
      end else begin
        cap_adr_r <= cap_adr_r;
        cap_ch_r  <= cap_ch_r;
      end
    end else if (clr_i) begin
      sts_r     <= {NCH{1'b0}};
      cap_adr_r <= {AW{1'b0}};
      cap_ch_r  <= 4'd0;
    end else begin
      sts_r     <= sts_r;
      cap_adr_r <= cap_adr_r;
      cap_ch_r  <= cap_ch_r;
    end
  end

  assign sts_o     = sts_r;
  assign cap_adr_o = cap_adr_r;
  assign cap_ch_o  = cap_ch_r;
`else
  logic unused_clr_s;

  assign unused_clr_s = clr_i;
  assign sts_o        = {NCH{1'b0}};
  assign cap_adr_o    = {AW{1'b0}};
  assign cap_ch_o     = 4'd0;
`endif

endmodule
